// File: rtl/peripheral_uart_receiver_wb.sv
// ---------------------------------------------------------------------------
// peripheral_uart_receiver_wb
//
// UART receive framer. It sits after the RX-line two-flop synchronizer and
// works from a 16x-baud tick. It finds and checks the start bit, then samples
// the data, parity and stop bits at bit centre. Each finished character is
// passed to the register/FIFO stage together with its error flags, using a
// valid/ack handshake.
//
// Optional feature (compile-time macro):
//   PERIPHERAL_UART_RX_MAJORITY_EN
//     Defined   : each bit decision is a 2-of-3 vote of srx_i taken at
//                 tcnt 6/7/8 (start bit) or 14/15/0 (other bits). The vote is
//                 decided on the third sample tick.
//     Undefined : each bit is a single sample at tcnt 7 (start bit) or
//                 tcnt 15 (other bits).
//
// Parameters:
//   DATA_W     : width of rx_data_o. Only 8 is supported; the character
//                length (5-8 bits) is chosen at run time.
//   IDLE_LEVEL : line level that means idle/mark.
//
// Ports:
//   clk_i          in   system clock
//   rst_i          in   synchronous reset, active-high
//   srx_i          in   RX line, already synchronized to clk_i
//   enable_i       in   16x-baud tick, one clk_i cycle wide
//   char_len_i     in   character length: 0=5, 1=6, 2=7, 3=8 bits
//   parity_en_i    in   a parity bit is expected when 1
//   parity_even_i  in   1=even parity, 0=odd parity
//   rx_ack_i       in   consumer has taken the current character
//   rx_data_o      out  received character (LSB first on line), upper bits 0
//   rx_valid_o     out  a character is held and valid
//   parity_err_o   out  parity mismatch on the held character
//   framing_err_o  out  stop bit sampled 0 on the held character
//   break_o        out  data, parity and stop bits all sampled 0
//   overrun_o      out  one-cycle pulse when an unacknowledged char is replaced
//   busy_o         out  receiver is not idle
// ---------------------------------------------------------------------------
module peripheral_uart_receiver_wb #(
    parameter int   DATA_W     = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              srx_i,
    input  logic              enable_i,
    input  logic [1:0]        char_len_i,
    input  logic              parity_en_i,
    input  logic              parity_even_i,
    input  logic              rx_ack_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              parity_err_o,
    output logic              framing_err_o,
    output logic              break_o,
    output logic              overrun_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        tcnt_q, tcnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [1:0]        len_q, len_d;
    logic              par_en_q, par_en_d;
    logic              par_even_q, par_even_d;
    logic              par_bit_q, par_bit_d;
    logic              par_err_q, par_err_d;
    logic              load;

    // The line is normalized so that 1 always means mark, whatever
    // IDLE_LEVEL is. Below, a start bit is therefore always a 0.
    logic srx_norm;
    assign srx_norm = srx_i ^ ~IDLE_LEVEL;

    // The value of the bit being decided, and the ticks on which the
    // start-bit and other-bit decisions are made.
    logic       bit_sample;
    logic       start_dec;
    logic       bit_dec;
    logic [2:0] last_bit;

`ifdef PERIPHERAL_UART_RX_MAJORITY_EN
    // Each decision moves one tick later, to the third vote sample. The
    // counter restarts at 1 on entry to DATA. This places the 14/15/0 vote
    // window around the centre of every later bit.
    localparam logic [3:0] START_DEC_TCNT = 4'd8;
    localparam logic [3:0] BIT_DEC_TCNT   = 4'd0;
    localparam logic [3:0] DATA_TCNT_INIT = 4'd1;

    logic       maj_a_q, maj_b_q;
    logic [3:0] vote_first_tcnt;

    assign vote_first_tcnt = (state_q == S_START) ? 4'd6 : 4'd14;

    // Hold the first two vote samples. The third sample is the live line
    // value on the decision tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            maj_a_q <= 1'b0;
            maj_b_q <= 1'b0;
        end else if (enable_i) begin
            if (tcnt_q == vote_first_tcnt) begin
                maj_a_q <= srx_norm;
            end
            if (tcnt_q == vote_first_tcnt + 4'd1) begin
                maj_b_q <= srx_norm;
            end
        end
    end

    assign bit_sample = (maj_a_q & maj_b_q) | (maj_a_q & srx_norm) | (maj_b_q & srx_norm);
`else
    localparam logic [3:0] START_DEC_TCNT = 4'd7;
    localparam logic [3:0] BIT_DEC_TCNT   = 4'd15;
    localparam logic [3:0] DATA_TCNT_INIT = 4'd0;

    assign bit_sample = srx_norm;
`endif

    assign start_dec = enable_i && (tcnt_q == START_DEC_TCNT);
    assign bit_dec   = enable_i && (tcnt_q == BIT_DEC_TCNT);

    // Index of the final data bit: character length minus one.
    assign last_bit  = {1'b0, len_q} + 3'd4;

    assign busy_o    = (state_q != S_IDLE);

    // Framing state register and receive datapath. The configuration is
    // latched at the START-to-DATA transition so that changes mid-frame
    // have no effect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            tcnt_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            len_q      <= '0;
            par_en_q   <= 1'b0;
            par_even_q <= 1'b0;
            par_bit_q  <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            par_even_q <= par_even_d;
            par_bit_q  <= par_bit_d;
            par_err_q  <= par_err_d;
        end
    end

    // Next-state logic. Nothing here moves except on a baud tick. The tick
    // counter runs freely inside a frame and wraps from 15 to 0, so bit
    // decisions come every 16 ticks.
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        len_d      = len_q;
        par_en_d   = par_en_q;
        par_even_d = par_even_q;
        par_bit_d  = par_bit_q;
        par_err_d  = par_err_q;
        load       = 1'b0;

        if (enable_i && (state_q != S_IDLE) && (state_q != S_WAIT_HIGH)) begin
            tcnt_d = tcnt_q + 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                tcnt_d = '0;
                if (enable_i && !srx_norm) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (start_dec) begin
                    if (bit_sample) begin
                        // The line is high again at bit centre, so this was
                        // a glitch and not a start bit.
                        state_d = S_IDLE;
                        tcnt_d  = '0;
                    end else begin
                        state_d    = S_DATA;
                        tcnt_d     = DATA_TCNT_INIT;
                        bit_cnt_d  = '0;
                        shift_d    = '0;
                        len_d      = char_len_i;
                        par_en_d   = parity_en_i;
                        par_even_d = parity_even_i;
                        par_bit_d  = 1'b0;
                        par_err_d  = 1'b0;
                    end
                end
            end

            S_DATA: begin
                if (bit_dec) begin
                    // Bits go straight to their own position. The register
                    // was cleared at frame start, so the bits above a short
                    // character stay 0.
                    shift_d[bit_cnt_q] = bit_sample;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == last_bit) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end

            S_PARITY: begin
                if (bit_dec) begin
                    // With even parity the XOR of data and parity must be 0.
                    // With odd parity it must be 1.
                    par_bit_d = bit_sample;
                    par_err_d = (^shift_q) ^ bit_sample ^ ~par_even_q;
                    state_d   = S_STOP;
                end
            end

            S_STOP: begin
                if (bit_dec) begin
                    load    = 1'b1;
                    state_d = bit_sample ? S_IDLE : S_WAIT_HIGH;
                    tcnt_d  = '0;
                end
            end

            S_WAIT_HIGH: begin
                // A held-low line (break) must not look like a new start
                // bit. Wait for mark first.
                tcnt_d = '0;
                if (enable_i && srx_norm) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                tcnt_d  = '0;
            end
        endcase
    end

    // Character holding register and handshake. A new load always wins,
    // even over a same-cycle ack. Overrun only pulses when the held
    // character was not being taken on that cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_data_o     <= '0;
            rx_valid_o    <= 1'b0;
            parity_err_o  <= 1'b0;
            framing_err_o <= 1'b0;
            break_o       <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (load) begin
                rx_data_o     <= shift_q;
                rx_valid_o    <= 1'b1;
                parity_err_o  <= par_en_q & par_err_q;
                framing_err_o <= ~bit_sample;
                break_o       <= (shift_q == '0) && !(par_en_q && par_bit_q) && !bit_sample;
                overrun_o     <= rx_valid_o && !rx_ack_i;
            end else if (rx_valid_o && rx_ack_i) begin
                rx_data_o     <= '0;
                rx_valid_o    <= 1'b0;
                parity_err_o  <= 1'b0;
                framing_err_o <= 1'b0;
                break_o       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_peripheral_uart_receiver_wb.sv
// ---------------------------------------------------------------------------
// tb_peripheral_uart_receiver_wb
//
// Directed testbench for peripheral_uart_receiver_wb. A baud tick arrives
// every 4 clocks. Each tick task returns one clock after the tick edge, so
// the registered outputs caused by that tick can be checked right away.
// ---------------------------------------------------------------------------
module tb_peripheral_uart_receiver_wb;

    logic       clk_i;
    logic       rst_i;
    logic       srx_i;
    logic       enable_i;
    logic [1:0] char_len_i;
    logic       parity_en_i;
    logic       parity_even_i;
    logic       rx_ack_i;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       parity_err_o;
    logic       framing_err_o;
    logic       break_o;
    logic       overrun_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;

    peripheral_uart_receiver_wb dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .srx_i         (srx_i),
        .enable_i      (enable_i),
        .char_len_i    (char_len_i),
        .parity_en_i   (parity_en_i),
        .parity_even_i (parity_even_i),
        .rx_ack_i      (rx_ack_i),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .parity_err_o  (parity_err_o),
        .framing_err_o (framing_err_o),
        .break_o       (break_o),
        .overrun_o     (overrun_o),
        .busy_o        (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        checkOutput(tag, {7'b0, observed}, {7'b0, expected});
    endtask

    // One baud tick: three idle clocks, then a clock with enable high.
    task automatic tick();
        repeat (3) @(negedge clk_i);
        enable_i = 1'b1;
        @(negedge clk_i);
        enable_i = 1'b0;
    endtask

    // Hold the line at a level for a number of ticks.
    task automatic applyStimulus(input logic level, input int n);
        srx_i = level;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Send a frame that stops just before the stop-bit decision tick. The
    // first 8 ticks of the stop bit are sent; the next tick is the decision.
    task automatic sendUntilStop(input logic [7:0] data, input int nbits,
                                 input logic with_par, input logic pbit, input logic stop);
        applyStimulus(1'b0, 16);
        for (int i = 0; i < nbits; i++) applyStimulus(data[i], 16);
        if (with_par) applyStimulus(pbit, 16);
        applyStimulus(stop, 8);
    endtask

    task automatic pulseAck();
        rx_ack_i = 1'b1;
        @(negedge clk_i);
        rx_ack_i = 1'b0;
    endtask

    initial begin
        rst_i         = 1'b1;
        srx_i         = 1'b1;
        enable_i      = 1'b0;
        char_len_i    = 2'd3;
        parity_en_i   = 1'b0;
        parity_even_i = 1'b1;
        rx_ack_i      = 1'b0;
        repeat (3) @(negedge clk_i);

        // Reset state
        checkOutput("reset_data", rx_data_o, 8'h00);
        checkFlag("reset_valid", rx_valid_o, 1'b0);
        checkFlag("reset_perr", parity_err_o, 1'b0);
        checkFlag("reset_ferr", framing_err_o, 1'b0);
        checkFlag("reset_break", break_o, 1'b0);
        checkFlag("reset_overrun", overrun_o, 1'b0);
        checkFlag("reset_busy", busy_o, 1'b0);
        rst_i = 1'b0;
        applyStimulus(1'b1, 4);

        // 8N1, 0xA5
        $display("[TB] 8N1 0xA5");
        sendUntilStop(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        checkFlag("a5_valid_before_stop", rx_valid_o, 1'b0);
        checkFlag("a5_busy", busy_o, 1'b1);
        applyStimulus(1'b1, 1);
        checkFlag("a5_valid", rx_valid_o, 1'b1);
        checkOutput("a5_data", rx_data_o, 8'hA5);
        checkFlag("a5_perr", parity_err_o, 1'b0);
        checkFlag("a5_ferr", framing_err_o, 1'b0);
        checkFlag("a5_break", break_o, 1'b0);
        applyStimulus(1'b1, 7);
        checkFlag("a5_valid_held", rx_valid_o, 1'b1);
        checkFlag("a5_busy_done", busy_o, 1'b0);
        pulseAck();
        checkFlag("a5_valid_after_ack", rx_valid_o, 1'b0);
        checkOutput("a5_data_after_ack", rx_data_o, 8'h00);

        // 7E1, 0x35 with correct (0) and wrong (1) parity bit
        $display("[TB] 7E1 0x35");
        char_len_i    = 2'd2;
        parity_en_i   = 1'b1;
        parity_even_i = 1'b1;
        sendUntilStop(8'h35, 7, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1);
        checkFlag("e1_valid", rx_valid_o, 1'b1);
        checkOutput("e1_data", rx_data_o, 8'h35);
        checkFlag("e1_perr", parity_err_o, 1'b0);
        checkFlag("e1_ferr", framing_err_o, 1'b0);
        applyStimulus(1'b1, 7);
        pulseAck();
        sendUntilStop(8'h35, 7, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1);
        checkOutput("e1_bad_data", rx_data_o, 8'h35);
        checkFlag("e1_bad_perr", parity_err_o, 1'b1);
        checkFlag("e1_bad_break", break_o, 1'b0);
        applyStimulus(1'b1, 7);
        pulseAck();
        checkFlag("e1_perr_cleared", parity_err_o, 1'b0);

        // Low glitch of 4 ticks
        $display("[TB] false start");
        char_len_i  = 2'd3;
        parity_en_i = 1'b0;
        applyStimulus(1'b0, 4);
        checkFlag("glitch_busy", busy_o, 1'b1);
        applyStimulus(1'b1, 12);
        checkFlag("glitch_idle", busy_o, 1'b0);
        checkFlag("glitch_valid", rx_valid_o, 1'b0);

        // Break: line low for 20 bit-times
        $display("[TB] break");
        applyStimulus(1'b0, 153);
        checkFlag("brk_valid", rx_valid_o, 1'b1);
        checkOutput("brk_data", rx_data_o, 8'h00);
        checkFlag("brk_ferr", framing_err_o, 1'b1);
        checkFlag("brk_break", break_o, 1'b1);
        checkFlag("brk_perr", parity_err_o, 1'b0);
        pulseAck();
        applyStimulus(1'b0, 167);
        checkFlag("brk_single_valid", rx_valid_o, 1'b0);
        checkFlag("brk_wait_high", busy_o, 1'b1);
        applyStimulus(1'b1, 1);
        checkFlag("brk_back_idle", busy_o, 1'b0);
        applyStimulus(1'b1, 16);
        checkFlag("brk_no_restart", rx_valid_o, 1'b0);

        // Back-to-back 5N1 0x1F then 0x0A, no ack
        $display("[TB] overrun");
        char_len_i = 2'd0;
        sendUntilStop(8'h1F, 5, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1);
        checkOutput("ovr_first_data", rx_data_o, 8'h1F);
        checkFlag("ovr_first_pulse", overrun_o, 1'b0);
        applyStimulus(1'b1, 7);
        sendUntilStop(8'h0A, 5, 1'b0, 1'b0, 1'b1);
        checkFlag("ovr_before_load", overrun_o, 1'b0);
        applyStimulus(1'b1, 1);
        checkFlag("ovr_pulse", overrun_o, 1'b1);
        checkOutput("ovr_data", rx_data_o, 8'h0A);
        checkFlag("ovr_valid", rx_valid_o, 1'b1);
        @(negedge clk_i);
        checkFlag("ovr_pulse_end", overrun_o, 1'b0);
        checkFlag("ovr_valid_kept", rx_valid_o, 1'b1);
        applyStimulus(1'b1, 7);

        // Reset during data bit 3 of 0xC3, with 0x0A still held
        $display("[TB] reset mid-frame");
        char_len_i = 2'd3;
        applyStimulus(1'b0, 16);
        applyStimulus(1'b1, 16);
        applyStimulus(1'b1, 16);
        applyStimulus(1'b0, 16);
        applyStimulus(1'b0, 8);
        checkFlag("rst_mid_busy_before", busy_o, 1'b1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        checkFlag("rst_mid_valid", rx_valid_o, 1'b0);
        checkOutput("rst_mid_data", rx_data_o, 8'h00);
        checkFlag("rst_mid_busy", busy_o, 1'b0);
        applyStimulus(1'b1, 40);
        checkFlag("rst_mid_no_valid", rx_valid_o, 1'b0);
        sendUntilStop(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1);
        checkFlag("post_rst_valid", rx_valid_o, 1'b1);
        checkOutput("post_rst_data", rx_data_o, 8'h5A);
        checkFlag("post_rst_ferr", framing_err_o, 1'b0);
        checkFlag("post_rst_overrun", overrun_o, 1'b0);
        applyStimulus(1'b1, 7);
        pulseAck();
        checkFlag("post_rst_ack", rx_valid_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
